// File: rtl/issue_dispatch_unit.sv
// Dispatch stage of the Tomasulo core: accepts one decoded instruction, allocates a ROB tag,
// resolves operands through regfile/ROB/CDB and issues it to the RS or LSB with a rename of rd.
module issue_dispatch_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int ROB_W    = 4,
  parameter int OPE_W    = 6,
  parameter int N_CDB    = 2,
  parameter int OP_NOP   = 0,
  parameter int OP_LS_LO = 18,
  parameter int OP_LS_HI = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [OPE_W-1:0]           in_op,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [REG_W-1:0]           in_rs1,
  input  logic [REG_W-1:0]           in_rs2,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic                       rob_full,
  input  logic [ROB_W:0]             rob_free_tag,
  output logic                       rob_alloc_en,
  output logic [REG_W-1:0]           rob_alloc_rd,
  output logic [ADDR_W-1:0]          rob_alloc_pc,
  output logic [REG_W-1:0]           rs1_to_reg,
  output logic [REG_W-1:0]           rs2_to_reg,
  input  logic [DATA_W-1:0]          v1_from_reg,
  input  logic [DATA_W-1:0]          v2_from_reg,
  input  logic [ROB_W:0]             q1_from_reg,
  input  logic [ROB_W:0]             q2_from_reg,
  output logic [ROB_W:0]             q1_to_rob,
  output logic [ROB_W:0]             q2_to_rob,
  input  logic                       q1_rdy_rob,
  input  logic                       q2_rdy_rob,
  input  logic [DATA_W-1:0]          q1_val_rob,
  input  logic [DATA_W-1:0]          q2_val_rob,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*(ROB_W+1)-1:0] cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]    cdb_data,
  input  logic                       rs_full,
  input  logic                       lsb_full,
  output logic                       ren_en,
  output logic [REG_W-1:0]           ren_rd,
  output logic [ROB_W:0]             ren_tag,
  output logic                       rs_en,
  output logic                       lsb_en,
  output logic [OPE_W-1:0]           iss_op,
  output logic [DATA_W-1:0]          iss_v1,
  output logic [DATA_W-1:0]          iss_v2,
  output logic [ROB_W:0]             iss_q1,
  output logic [ROB_W:0]             iss_q2,
  output logic [ADDR_W-1:0]          iss_pc,
  output logic [DATA_W-1:0]          iss_imm,
  output logic [ROB_W:0]             iss_tag
);

  localparam int TAG_W = ROB_W + 1;
  localparam logic [OPE_W-1:0] NOP_OP = OPE_W'(OP_NOP);
  localparam logic [OPE_W-1:0] LS_LO  = OPE_W'(OP_LS_LO);
  localparam logic [OPE_W-1:0] LS_HI  = OPE_W'(OP_LS_HI);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  state_t state;

  logic [ADDR_W-1:0] h_pc;
  logic [OPE_W-1:0]  h_op;
  logic [REG_W-1:0]  h_rd;
  logic [DATA_W-1:0] h_imm;
  logic [TAG_W-1:0]  h_tag;
  logic [TAG_W-1:0]  h_q1, h_q2;
  logic [DATA_W-1:0] h_v1, h_v2;

  logic [TAG_W+DATA_W-1:0] r1, r2;
  logic [TAG_W-1:0]        res_q1, res_q2;
  logic [DATA_W-1:0]       res_v1, res_v2;
  logic                    is_ls, tgt_full, accept;

  // Priority: already ready, then ROB result, then lowest matching CDB channel; unresolved keeps Q with V=0.
  function automatic logic [TAG_W+DATA_W-1:0] resolve(
    input logic [TAG_W-1:0]        q,
    input logic [DATA_W-1:0]       v,
    input logic                    rob_rdy,
    input logic [DATA_W-1:0]       rob_val,
    input logic [N_CDB-1:0]        cv,
    input logic [N_CDB*TAG_W-1:0]  ct,
    input logic [N_CDB*DATA_W-1:0] cd
  );
    logic [TAG_W+DATA_W-1:0] r;
    r = {q, {DATA_W{1'b0}}};
    if (q == '0) begin
      r = {q, v};
    end else if (rob_rdy) begin
      r = {{TAG_W{1'b0}}, rob_val};
    end else begin
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (cv[c] && (ct[c*TAG_W +: TAG_W] == q)) r = {{TAG_W{1'b0}}, cd[c*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign q1_to_rob = q1_from_reg;
  assign q2_to_rob = q2_from_reg;
  assign in_ready  = rdy & ~flush & (state == IDLE) & ~rob_full;
  assign accept    = in_valid & in_ready;
  assign is_ls     = (h_op >= LS_LO) && (h_op <= LS_HI);
  assign tgt_full  = is_ls ? lsb_full : rs_full;

  // In STALL the operands come from the held copy and only the CDB can wake them.
  always_comb begin
    r1 = '0;
    r2 = '0;
    if (state == STALL) begin
      r1 = resolve(h_q1, h_v1, 1'b0, '0, cdb_valid, cdb_tag, cdb_data);
      r2 = resolve(h_q2, h_v2, 1'b0, '0, cdb_valid, cdb_tag, cdb_data);
    end else begin
      r1 = resolve(q1_from_reg, v1_from_reg, q1_rdy_rob, q1_val_rob, cdb_valid, cdb_tag, cdb_data);
      r2 = resolve(q2_from_reg, v2_from_reg, q2_rdy_rob, q2_val_rob, cdb_valid, cdb_tag, cdb_data);
    end
  end

  assign {res_q1, res_v1} = r1;
  assign {res_q2, res_v2} = r2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rob_alloc_en <= 1'b0;
      rs_en        <= 1'b0;
      lsb_en       <= 1'b0;
      ren_en       <= 1'b0;
      rob_alloc_rd <= '0;
      rob_alloc_pc <= '0;
      rs1_to_reg   <= '0;
      rs2_to_reg   <= '0;
      ren_rd       <= '0;
      ren_tag      <= '0;
      iss_op       <= '0;
      iss_v1       <= '0;
      iss_v2       <= '0;
      iss_q1       <= '0;
      iss_q2       <= '0;
      iss_pc       <= '0;
      iss_imm      <= '0;
      iss_tag      <= '0;
      h_pc         <= '0;
      h_op         <= '0;
      h_rd         <= '0;
      h_imm        <= '0;
      h_tag        <= '0;
      h_q1         <= '0;
      h_q2         <= '0;
      h_v1         <= '0;
      h_v2         <= '0;
    end else if (!rdy) begin
      rob_alloc_en <= 1'b0;
      rs_en        <= 1'b0;
      lsb_en       <= 1'b0;
      ren_en       <= 1'b0;
    end else begin
      rob_alloc_en <= 1'b0;
      rs_en        <= 1'b0;
      lsb_en       <= 1'b0;
      ren_en       <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // NOPs are consumed here and never reach the ROB.
            if (accept && (in_op != NOP_OP)) begin
              h_pc         <= in_pc;
              h_op         <= in_op;
              h_rd         <= in_rd;
              h_imm        <= in_imm;
              h_tag        <= rob_free_tag;
              rs1_to_reg   <= in_rs1;
              rs2_to_reg   <= in_rs2;
              rob_alloc_en <= 1'b1;
              rob_alloc_rd <= in_rd;
              rob_alloc_pc <= in_pc;
              state        <= ISSUE;
            end
          end
          ISSUE, STALL: begin
            if (tgt_full) begin
              h_q1  <= res_q1;
              h_v1  <= res_v1;
              h_q2  <= res_q2;
              h_v2  <= res_v2;
              state <= STALL;
            end else begin
              rs_en   <= ~is_ls;
              lsb_en  <= is_ls;
              iss_op  <= h_op;
              iss_v1  <= res_v1;
              iss_v2  <= res_v2;
              iss_q1  <= res_q1;
              iss_q2  <= res_q2;
              iss_pc  <= h_pc;
              iss_imm <= h_imm;
              iss_tag <= h_tag;
              ren_en  <= (h_rd != '0);
              ren_rd  <= h_rd;
              ren_tag <= h_tag;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Directed bench for issue_dispatch_unit: one task per scenario with hand-computed expectations.
module tb_issue_dispatch_unit;

  logic        clk, rst, rdy, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_imm;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        rob_full;
  logic [4:0]  rob_free_tag;
  logic        rob_alloc_en;
  logic [4:0]  rob_alloc_rd;
  logic [31:0] rob_alloc_pc;
  logic [4:0]  rs1_to_reg, rs2_to_reg;
  logic [31:0] v1_from_reg, v2_from_reg;
  logic [4:0]  q1_from_reg, q2_from_reg, q1_to_rob, q2_to_rob;
  logic        q1_rdy_rob, q2_rdy_rob;
  logic [31:0] q1_val_rob, q2_val_rob;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        rs_full, lsb_full;
  logic        ren_en;
  logic [4:0]  ren_rd, ren_tag;
  logic        rs_en, lsb_en;
  logic [5:0]  iss_op;
  logic [31:0] iss_v1, iss_v2, iss_pc, iss_imm;
  logic [4:0]  iss_q1, iss_q2, iss_tag;

  int checks = 0;
  int errors = 0;

  issue_dispatch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .rob_full(rob_full), .rob_free_tag(rob_free_tag), .rob_alloc_en(rob_alloc_en),
    .rob_alloc_rd(rob_alloc_rd), .rob_alloc_pc(rob_alloc_pc),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .v1_from_reg(v1_from_reg), .v2_from_reg(v2_from_reg),
    .q1_from_reg(q1_from_reg), .q2_from_reg(q2_from_reg),
    .q1_to_rob(q1_to_rob), .q2_to_rob(q2_to_rob),
    .q1_rdy_rob(q1_rdy_rob), .q2_rdy_rob(q2_rdy_rob),
    .q1_val_rob(q1_val_rob), .q2_val_rob(q2_val_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .ren_en(ren_en), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .rs_en(rs_en), .lsb_en(lsb_en), .iss_op(iss_op), .iss_v1(iss_v1), .iss_v2(iss_v2),
    .iss_q1(iss_q1), .iss_q2(iss_q2), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_tag(iss_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [5:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_pc = pc; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic clear_operands();
    v1_from_reg = '0; v2_from_reg = '0; q1_from_reg = '0; q2_from_reg = '0;
    q1_rdy_rob = 0; q2_rdy_rob = 0; q1_val_rob = '0; q2_val_rob = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; rdy = 1; flush = 0; in_valid = 0; rob_full = 0; rob_free_tag = 5'd1;
    rs_full = 0; lsb_full = 0;
    set_instr(32'h0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    clear_operands();
    tick(); tick();
    checks++; if ({rob_alloc_en, rs_en, lsb_en, ren_en} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_en got %b exp 0000", {rob_alloc_en, rs_en, lsb_en, ren_en}); end
    checks++; if ({iss_v1, iss_tag, rs1_to_reg} !== 42'h0) begin errors++; $display("[TB] FAIL reset_payload got %h exp 0", {iss_v1, iss_tag, rs1_to_reg}); end
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    set_instr(32'h40, 6'd1, 5'd3, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd6; v1_from_reg = 32'd5; v2_from_reg = 32'd7;
    in_valid = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if ({rob_alloc_en, rob_alloc_rd, rob_alloc_pc} !== {1'b1, 5'd3, 32'h40}) begin errors++; $display("[TB] FAIL add_alloc got %h exp %h", {rob_alloc_en, rob_alloc_rd, rob_alloc_pc}, {1'b1, 5'd3, 32'h40}); end
    checks++; if ({rs1_to_reg, rs2_to_reg, in_ready} !== {5'd1, 5'd2, 1'b0}) begin errors++; $display("[TB] FAIL add_regaddr got %h exp %h", {rs1_to_reg, rs2_to_reg, in_ready}, {5'd1, 5'd2, 1'b0}); end
    tick();
    checks++; if ({rs_en, lsb_en, ren_en, rob_alloc_en} !== 4'b1010) begin errors++; $display("[TB] FAIL add_pulses got %b exp 1010", {rs_en, lsb_en, ren_en, rob_alloc_en}); end
    checks++; if ({iss_v1, iss_v2, iss_q1, iss_q2} !== {32'd5, 32'd7, 5'd0, 5'd0}) begin errors++; $display("[TB] FAIL add_operands got %h exp %h", {iss_v1, iss_v2, iss_q1, iss_q2}, {32'd5, 32'd7, 5'd0, 5'd0}); end
    checks++; if ({ren_rd, ren_tag, iss_tag, iss_pc} !== {5'd3, 5'd6, 5'd6, 32'h40}) begin errors++; $display("[TB] FAIL add_rename got %h exp %h", {ren_rd, ren_tag, iss_tag, iss_pc}, {5'd3, 5'd6, 5'd6, 32'h40}); end
    tick();
    checks++; if ({rs_en, ren_en} !== 2'b00) begin errors++; $display("[TB] FAIL add_one_cycle got %b exp 00", {rs_en, ren_en}); end
    clear_operands();
  endtask

  task automatic test_load();
    set_instr(32'h44, 6'd20, 5'd4, 5'd1, 5'd0, 32'd8);
    rob_free_tag = 5'd7; q1_from_reg = 5'd3; q1_rdy_rob = 1; q1_val_rob = 32'h100; v1_from_reg = 32'hdead;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    checks++; if ({rs_en, lsb_en, ren_en} !== 3'b011) begin errors++; $display("[TB] FAIL load_pulses got %b exp 011", {rs_en, lsb_en, ren_en}); end
    checks++; if ({iss_v1, iss_q1, iss_imm, iss_op} !== {32'h100, 5'd0, 32'd8, 6'd20}) begin errors++; $display("[TB] FAIL load_payload got %h exp %h", {iss_v1, iss_q1, iss_imm, iss_op}, {32'h100, 5'd0, 32'd8, 6'd20}); end
    checks++; if ({ren_rd, ren_tag} !== {5'd4, 5'd7}) begin errors++; $display("[TB] FAIL load_rename got %h exp %h", {ren_rd, ren_tag}, {5'd4, 5'd7}); end
    tick();
    clear_operands();
  endtask

  task automatic test_stall_cdb();
    set_instr(32'h48, 6'd1, 5'd5, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd8; v1_from_reg = 32'd11; q2_from_reg = 5'd5; v2_from_reg = 32'h33; rs_full = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    checks++; if (rs_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_issue_cycle got %b exp 0", rs_en); end
    q2_from_reg = 5'd0; v2_from_reg = 32'h0;
    cdb_valid = 2'b11; cdb_tag = {5'd5, 5'd4}; cdb_data = {32'd9, 32'h55};
    tick();
    checks++; if (rs_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_cdb_cycle got %b exp 0", rs_en); end
    cdb_valid = 2'b00; cdb_tag = '0; cdb_data = '0;
    tick();
    checks++; if (rs_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_third got %b exp 0", rs_en); end
    rs_full = 0;
    tick();
    checks++; if ({rs_en, ren_en} !== 2'b11) begin errors++; $display("[TB] FAIL stall_release got %b exp 11", {rs_en, ren_en}); end
    checks++; if ({iss_v1, iss_q1, iss_v2, iss_q2, iss_tag} !== {32'd11, 5'd0, 32'd9, 5'd0, 5'd8}) begin errors++; $display("[TB] FAIL stall_payload got %h exp %h", {iss_v1, iss_q1, iss_v2, iss_q2, iss_tag}, {32'd11, 5'd0, 32'd9, 5'd0, 5'd8}); end
    tick();
    clear_operands();
  endtask

  task automatic test_cdb_priority();
    set_instr(32'h4c, 6'd1, 5'd6, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd9; q1_from_reg = 5'd2; q2_from_reg = 5'd3; v2_from_reg = 32'h77;
    in_valid = 1;
    tick();
    in_valid = 0;
    cdb_valid = 2'b11; cdb_tag = {5'd2, 5'd2}; cdb_data = {32'hb, 32'ha};
    tick();
    checks++; if (rs_en !== 1'b1) begin errors++; $display("[TB] FAIL prio_rs_en got %b exp 1", rs_en); end
    checks++; if ({iss_v1, iss_q1, iss_v2, iss_q2} !== {32'ha, 5'd0, 32'h0, 5'd3}) begin errors++; $display("[TB] FAIL prio_operands got %h exp %h", {iss_v1, iss_q1, iss_v2, iss_q2}, {32'ha, 5'd0, 32'h0, 5'd3}); end
    tick();
    clear_operands();
  endtask

  task automatic test_x0_nop();
    set_instr(32'h50, 6'd2, 5'd0, 5'd1, 5'd0, 32'd1);
    rob_free_tag = 5'd10; v1_from_reg = 32'd4;
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++; if (rob_alloc_en !== 1'b1) begin errors++; $display("[TB] FAIL x0_alloc got %b exp 1", rob_alloc_en); end
    tick();
    checks++; if ({rs_en, lsb_en, ren_en} !== 3'b100) begin errors++; $display("[TB] FAIL x0_pulses got %b exp 100", {rs_en, lsb_en, ren_en}); end
    set_instr(32'h54, 6'd0, 5'd1, 5'd0, 5'd0, 32'h0);
    in_valid = 1;
    tick();
    checks++; if ({rob_alloc_en, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL nop_drop got %b exp 01", {rob_alloc_en, in_ready}); end
    tick();
    in_valid = 0;
    checks++; if ({rs_en, rob_alloc_en} !== 2'b00) begin errors++; $display("[TB] FAIL nop_no_issue got %b exp 00", {rs_en, rob_alloc_en}); end
    clear_operands();
  endtask

  task automatic test_flush();
    set_instr(32'h58, 6'd1, 5'd7, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd11; rs_full = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    set_instr(32'h5c, 6'd1, 5'd8, 5'd1, 5'd2, 32'h0);
    flush = 1; rs_full = 0; in_valid = 1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready got %b exp 0", in_ready); end
    tick();
    checks++; if ({rs_en, lsb_en, ren_en, rob_alloc_en} !== 4'b0000) begin errors++; $display("[TB] FAIL flush_pulses got %b exp 0000", {rs_en, lsb_en, ren_en, rob_alloc_en}); end
    flush = 0; in_valid = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after got %b exp 1", in_ready); end
    tick();
    checks++; if ({rs_en, ren_en} !== 2'b00) begin errors++; $display("[TB] FAIL flush_dropped got %b exp 00", {rs_en, ren_en}); end
    rob_full = 1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rob_full_ready got %b exp 0", in_ready); end
    rob_full = 0;
  endtask

  task automatic test_rdy_freeze();
    set_instr(32'h60, 6'd1, 5'd9, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd12; v1_from_reg = 32'd1; v2_from_reg = 32'd2;
    in_valid = 1;
    tick();
    in_valid = 0; rdy = 0;
    checks++; if (rob_alloc_en !== 1'b1) begin errors++; $display("[TB] FAIL rdy_alloc got %b exp 1", rob_alloc_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({rs_en, lsb_en, ren_en, rob_alloc_en} !== 4'b0000) begin errors++; $display("[TB] FAIL rdy_frozen_%0d got %b exp 0000", i, {rs_en, lsb_en, ren_en, rob_alloc_en}); end
    end
    rdy = 1;
    tick();
    checks++; if ({rs_en, ren_en, ren_rd, iss_v1} !== {2'b11, 5'd9, 32'd1}) begin errors++; $display("[TB] FAIL rdy_resume got %h exp %h", {rs_en, ren_en, ren_rd, iss_v1}, {2'b11, 5'd9, 32'd1}); end
    rdy = 0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rdy_low_ready got %b exp 0", in_ready); end
    rdy = 1;
    tick();
    clear_operands();
  endtask

  task automatic test_back_to_back();
    set_instr(32'h64, 6'd1, 5'd1, 5'd1, 5'd2, 32'h0);
    rob_free_tag = 5'd13;
    in_valid = 1;
    tick();
    checks++; if ({rob_alloc_en, rob_alloc_rd} !== {1'b1, 5'd1}) begin errors++; $display("[TB] FAIL b2b_alloc_a got %h exp %h", {rob_alloc_en, rob_alloc_rd}, {1'b1, 5'd1}); end
    set_instr(32'h68, 6'd1, 5'd2, 5'd3, 5'd4, 32'h0);
    rob_free_tag = 5'd14;
    tick();
    checks++; if ({rs_en, ren_rd, ren_tag, rob_alloc_en, in_ready} !== {1'b1, 5'd1, 5'd13, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL b2b_issue_a got %h exp %h", {rs_en, ren_rd, ren_tag, rob_alloc_en, in_ready}, {1'b1, 5'd1, 5'd13, 1'b0, 1'b1}); end
    tick();
    in_valid = 0;
    checks++; if ({rob_alloc_en, rob_alloc_rd, rob_alloc_pc} !== {1'b1, 5'd2, 32'h68}) begin errors++; $display("[TB] FAIL b2b_alloc_b got %h exp %h", {rob_alloc_en, rob_alloc_rd, rob_alloc_pc}, {1'b1, 5'd2, 32'h68}); end
    tick();
    checks++; if ({rs_en, ren_tag, iss_pc} !== {1'b1, 5'd14, 32'h68}) begin errors++; $display("[TB] FAIL b2b_issue_b got %h exp %h", {rs_en, ren_tag, iss_pc}, {1'b1, 5'd14, 32'h68}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_stall_cdb();
    test_cdb_priority();
    test_x0_nop();
    test_flush();
    test_rdy_freeze();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
